// File: rtl/pcpu_mem_arbiter.sv
// Three-way arbiter (data > fetch > loader) sharing one single-port synchronous RAM.
// Optional loader anti-starvation guard: define ARB_STARVE_GUARD_EN.
module pcpu_mem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    input  logic          x_req,
    input  logic          x_we,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_wdata,
    output logic          x_ack,
    output logic [DW-1:0] x_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          stall
);

    // tag      | meaning
    // TAG_NONE | no access in flight
    // TAG_I    | fetch granted last cycle, acked this cycle
    // TAG_D    | data access granted last cycle, acked this cycle
    // TAG_X    | loader access granted last cycle, acked this cycle
    typedef enum logic [1:0] {TAG_NONE, TAG_I, TAG_D, TAG_X} tag_t;

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    tag_t          tag_q;
    tag_t          grant;
    logic          rd_q;
    logic [DW-1:0] i_hold, d_hold, x_hold;
    logic          i_elig, d_elig, x_elig;
    logic          force_x;

    assign i_elig = i_req && (tag_q != TAG_I);
    assign d_elig = d_req && (tag_q != TAG_D);
    assign x_elig = x_req && (tag_q != TAG_X);

    // Acks are masked during reset so an interrupted access never completes its handshake.
    assign i_ack = (tag_q == TAG_I) && !reset;
    assign d_ack = (tag_q == TAG_D) && !reset;
    assign x_ack = (tag_q == TAG_X) && !reset;

    assign i_rdata = (i_ack && rd_q) ? m_rdata : i_hold;
    assign d_rdata = (d_ack && rd_q) ? m_rdata : d_hold;
    assign x_rdata = (x_ack && rd_q) ? m_rdata : x_hold;

    assign stall = (i_req && !i_ack) || (d_req && !d_ack);

    always_comb begin
        grant = TAG_NONE;
        if (!reset) begin
            if (force_x)     grant = TAG_X;
            else if (d_elig) grant = TAG_D;
            else if (i_elig) grant = TAG_I;
            else if (x_elig) grant = TAG_X;
        end
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        case (grant)
            TAG_I: begin
                m_en   = 1'b1;
                m_addr = i_addr;
            end
            TAG_D: begin
                m_en    = 1'b1;
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end
            TAG_X: begin
                m_en    = 1'b1;
                m_we    = x_we;
                m_addr  = x_addr;
                m_wdata = x_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q  <= TAG_NONE;
            rd_q   <= 1'b0;
            i_hold <= '0;
            d_hold <= '0;
            x_hold <= '0;
        end else begin
            tag_q <= grant;
            rd_q  <= !m_we;
            if (i_ack && rd_q) i_hold <= m_rdata;
            if (d_ack && rd_q) d_hold <= m_rdata;
            if (x_ack && rd_q) x_hold <= m_rdata;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;

    assign force_x = x_elig && (starve_cnt == STARVE_LIM);

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!x_req || grant == TAG_X) begin
            starve_cnt <= '0;
        end else if (x_elig && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    assign force_x = 1'b0;
`endif

endmodule

// File: tb/tb_pcpu_mem_arbiter.sv
// Scoreboard bench for pcpu_mem_arbiter: directed scenarios plus randomized three-port traffic.
module tb_pcpu_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [7:0]  i_addr = '0;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        x_req = 1'b0, x_we = 1'b0;
    logic [7:0]  x_addr = '0;
    logic [15:0] x_wdata = '0;
    logic        x_ack;
    logic [15:0] x_rdata;
    logic        m_en, m_we;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata = '0;
    logic        stall;

    always #5 clock = ~clock;

    pcpu_mem_arbiter #(.AW(8), .DW(16), .STARVE_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_ack(x_ack), .x_rdata(x_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .stall(stall)
    );

    function automatic logic [15:0] init_val(input int k);
        if (k == 16'h10) return 16'hABCD;
        if (k == 16'h11) return 16'h3C00;
        return 16'(k * 16'h0123) ^ 16'h5A5A;
    endfunction

    logic        fill = 1'b1;
    logic [15:0] ram [256];
    always @(posedge clock) begin
        if (fill) begin
            for (int k = 0; k < 256; k++) ram[k] <= init_val(k);
        end else if (m_en) begin
            if (m_we) ram[m_addr] <= m_wdata;
            else      m_rdata     <= ram[m_addr];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic        rd;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q [3][$];
    logic [15:0] ref_mem [256];
    logic [15:0] hold_m [3];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    function automatic logic get_ack(input int p);
        case (p)
            0:       return i_ack;
            1:       return d_ack;
            default: return x_ack;
        endcase
    endfunction

    function automatic logic [15:0] get_rdata(input int p);
        case (p)
            0:       return i_rdata;
            1:       return d_rdata;
            default: return x_rdata;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected result comes from the port's view of memory at issue time.
    task automatic set_req(input int p, input logic we, input logic [7:0] a, input logic [15:0] wd);
        exp_t e;
        e.rd   = !we;
        e.data = we ? wd : ref_mem[a];
        if (we) ref_mem[a] = wd;
        exp_q[p].push_back(e);
        case (p)
            0: begin i_req = 1'b1; i_addr = a; end
            1: begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
            default: begin x_req = 1'b1; x_we = we; x_addr = a; x_wdata = wd; end
        endcase
    endtask

    task automatic clr_req(input int p);
        case (p)
            0: i_req = 1'b0;
            1: begin d_req = 1'b0; d_we = 1'b0; end
            default: begin x_req = 1'b0; x_we = 1'b0; end
        endcase
    endtask

    task automatic wait_ack(input int p, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if (get_ack(p)) return;
        end
        check($sformatf("ack_timeout_p%0d", p), 0, 1);
    endtask

    task automatic xact(input int p, input logic we, input logic [7:0] a, input logic [15:0] wd);
        set_req(p, we, a, wd);
        wait_ack(p, 100);
        tick();
        clr_req(p);
    endtask

    // Monitor: pops expectations on every ack, tracks each port's hold value.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            for (int p = 0; p < 3; p++) begin
                exp_q[p].delete();
                hold_m[p] = '0;
            end
        end else begin
            check("single_ack", 32'($countones({i_ack, d_ack, x_ack}) <= 1), 1);
            for (int p = 0; p < 3; p++) begin
                if (get_ack(p)) begin
                    if (exp_q[p].size() == 0) begin
                        check($sformatf("spurious_ack_p%0d", p), 1, 0);
                    end else begin
                        e = exp_q[p].pop_front();
                        if (e.rd) begin
                            check($sformatf("rdata_p%0d", p), get_rdata(p), e.data);
                            hold_m[p] = e.data;
                        end else begin
                            check($sformatf("wr_hold_p%0d", p), get_rdata(p), hold_m[p]);
                        end
                    end
                end else begin
                    check($sformatf("hold_p%0d", p), get_rdata(p), hold_m[p]);
                end
            end
            if (!i_req && !d_req && !x_req)
                check("idle_bus", {m_en, m_we, m_addr, m_wdata}, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    int c0, prev, off, men_cnt;

    initial begin
        for (int k = 0; k < 256; k++) ref_mem[k] = init_val(k);
        for (int p = 0; p < 3; p++) hold_m[p] = '0;
        tick();
        fill = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // reset then idle
        repeat (5) begin
            @(negedge clock);
            check("idle_m_en", m_en, 0);
            check("idle_acks", {i_ack, d_ack, x_ack}, 0);
            check("idle_stall", stall, 0);
            check("idle_rdata", {i_rdata, d_rdata, x_rdata}, 0);
        end

        // loader write then fetch of the same address
        tick();
        c0 = cyc;
        set_req(2, 1'b1, 8'h00, 16'h8162);
        @(negedge clock);
        check("xw_bus", {m_en, m_we, m_addr, m_wdata}, {2'b11, 8'h00, 16'h8162});
        wait_ack(2, 10);
        check("xw_latency", cyc - c0, 1);
        tick();
        clr_req(2);
        c0 = cyc;
        set_req(0, 1'b0, 8'h00, 16'h0);
        wait_ack(0, 10);
        check("ifetch_latency", cyc - c0, 1);
        check("ifetch_data", i_rdata, 16'h8162);
        tick();
        clr_req(0);
        @(negedge clock);
        check("ifetch_hold", i_rdata, 16'h8162);

        // d and i contend in the same cycle
        tick();
        set_req(1, 1'b0, 8'h10, 16'h0);
        set_req(0, 1'b0, 8'h11, 16'h0);
        @(negedge clock);
        check("cont_stall_n", stall, 1);
        check("cont_addr_n", m_addr, 8'h10);
        @(negedge clock);
        check("cont_acks_n1", {d_ack, i_ack}, 2'b10);
        check("cont_d_data", d_rdata, 16'hABCD);
        check("cont_stall_n1", stall, 1);
        check("cont_addr_n1", m_addr, 8'h11);
        tick();
        clr_req(1);
        @(negedge clock);
        check("cont_i_ack_n2", i_ack, 1);
        check("cont_i_data", i_rdata, 16'h3C00);
        check("cont_stall_n2", stall, 0);
        tick();
        clr_req(0);

        // reset while a data read is in flight
        tick();
        set_req(1, 1'b0, 8'h10, 16'h0);
        @(negedge clock);
        check("rst_grant", m_en, 1);
        tick();
        reset = 1'b1;
        clr_req(1);
        @(negedge clock);
        check("rst_no_ack", d_ack, 0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_m_en", m_en, 0);
        check("rst_d_rdata", d_rdata, 16'h0000);

        // fetch-only throughput: one ack every two cycles
        tick();
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1'b0, 8'(k), 16'h0);
            wait_ack(0, 10);
            if (k > 0) check("i_ack_spacing", cyc - prev, 2);
            prev = cyc;
            tick();
            clr_req(0);
        end

        // d and i together keep the RAM busy every cycle
        tick();
        men_cnt = 0;
        fork
            for (int k = 0; k < 8; k++) xact(0, 1'b0, 8'(k), 16'h0);
            for (int k = 0; k < 8; k++) xact(1, 1'b0, 8'(8'h20 + k), 16'h0);
            repeat (16) begin
                @(negedge clock);
                if (m_en) men_cnt++;
            end
        join
        check("busy_cycles", men_cnt, 16);

        // loader against continuous CPU traffic
        tick();
        off = 0;
        fork
            for (int k = 0; k < 30; k++) xact(1, 1'b0, 8'($urandom_range(0, 63)), 16'h0);
            for (int k = 0; k < 30; k++) xact(0, 1'b0, 8'(8'h80 + $urandom_range(0, 127)), 16'h0);
            begin
                c0 = cyc;
                set_req(2, 1'b0, 8'h40, 16'h0);
                wait_ack(2, 100);
                off = cyc - c0;
                tick();
                clr_req(2);
            end
        join
`ifdef ARB_STARVE_GUARD_EN
        check("starve_forced_ack", off, 5);
`else
        check("starve_no_ack_50", 32'(off >= 50), 1);
`endif

        // randomized traffic, each port in its own address region
        tick();
        fork
            for (int t = 0; t < 40; t++) begin
                repeat ($urandom_range(0, 3)) tick();
                xact(0, 1'b0, 8'(8'h80 + $urandom_range(0, 127)), 16'h0);
            end
            for (int t = 0; t < 40; t++) begin
                repeat ($urandom_range(0, 3)) tick();
                xact(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), 16'($urandom));
            end
            for (int t = 0; t < 40; t++) begin
                repeat ($urandom_range(0, 3)) tick();
                xact(2, 1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 63)), 16'($urandom));
            end
        join

        repeat (3) tick();
        for (int p = 0; p < 3; p++)
            check($sformatf("leftover_p%0d", p), exp_q[p].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcpu_mem_arbiter.md
# pcpu_mem_arbiter

Unified-memory arbiter for the 16-bit pipeline CPU. It shares one single-port synchronous 256x16 RAM between three requesters: the CPU instruction fetch port, the CPU data port, and an external loader/debug port. It issues at most one RAM access per cycle and returns a one-cycle ack to the winner. It also drives a stall to the CPU while a fetch or data request is waiting.

## Interface
Parameters:
- AW, 8, address width (matches CPU i_addr/d_addr)
- DW, 16, data width
- STARVE_MAX, 4, consecutive lost cycles before the loader port is forced to win (guard build only)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address
- i_ack  out  1  one-cycle fetch completion
- i_rdata  out  DW  fetch data
- d_req, d_we  in  1  data request; write when d_we=1
- d_addr  in  AW, d_wdata  in  DW
- d_ack  out  1, d_rdata  out  DW
- x_req, x_we  in  1  loader/debug request
- x_addr  in  AW, x_wdata  in  DW
- x_ack  out  1, x_rdata  out  DW
- m_en, m_we  out  1  RAM enable and write strobe
- m_addr  out  AW, m_wdata  out  DW
- m_rdata  in  DW  RAM read data, valid the cycle after m_en
- stall  out  1  CPU pipeline hold

## Operation
- Requesters hold req, we, addr and wdata stable from assertion through their ack cycle. They deassert req, or present a new request, in the cycle after ack.
- Eligible requesters: req=1 and not in flight. In-flight means granted in the previous cycle, so that requester is acked this cycle.
- Priority: d > i > x, unless the starvation guard forces x (see Configuration).
- Grant cycle N: the winner's fields drive m_en=1, m_we, m_addr, m_wdata combinationally. The winner's ID is registered as the in-flight tag.
- Ack cycle N+1: the in-flight requester's ack=1.
  - Read: its rdata = m_rdata combinationally, and m_rdata is loaded into that port's hold register.
  - Write: the hold register is unchanged.
- Outside its read-ack cycle, each rdata shows its hold register.
- A different requester may be granted in cycle N+1. Sustained throughput is 1 access per cycle.
- stall = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.
- No grant: m_en=0, m_we=0, m_addr and m_wdata driven 0.

## Timing
- Reset values:
  - Registers: in-flight tag = none; all acks 0; rdata hold registers 0x0000; starvation counter 0.
  - Combinational outputs when all req=0: m_en=m_we=0, m_addr=0, m_wdata=0, stall=0.
- Latency: req seen in cycle N with no higher-priority competitor -> ack in N+1. Minimum CPU stall per access is 1 cycle.
- Simultaneous i and d: d granted at N and acked at N+1; i granted at N+1 and acked at N+2. stall stays high N..N+1.
- Back-to-back same requester: after ack at N+1, a new request from that port is eligible at N+2. The port cannot be regranted at N+1.
- Write-then-read of the same address by different ports in consecutive cycles: the read returns the newly written value, provided the RAM is write-first or the two accesses are in different cycles. The arbiter never reorders accesses.
- Reset asserted mid-access:
  - No ack is emitted for the in-flight access. Any write already presented to the RAM in its grant cycle completes.
  - Next cycle: tag cleared, m_en=0, hold registers 0.
- Address wrap: addresses are used unmodified. The arbiter performs no arithmetic on them.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments each cycle x is eligible but loses. It clears on x grant or when x_req=0, and saturates at STARVE_MAX.
  - When the counter equals STARVE_MAX, x wins the next arbitration over d and i.
- ARB_STARVE_GUARD_EN undefined: strict d > i > x priority. No counter is instantiated, and x may starve indefinitely under continuous CPU traffic.

## Test plan
- Reset then idle: all req=0 for 5 cycles -> m_en=0, all acks 0, all rdata=0x0000, stall=0.
- Loader write then CPU fetch: x writes 0x8162 to addr 0x00; i reads 0x00 two cycles later -> x_ack at N+1, i_ack with i_rdata=0x8162, and i_rdata holds 0x8162 afterwards.
- Contention: d read 0x10 (RAM=0xABCD) and i read 0x11 (RAM=0x3C00) raised in the same cycle -> d_ack at N+1 with 0xABCD; i_ack at N+2 with 0x3C00; stall high for cycles N and N+1.
- Starvation, guard build with STARVE_MAX=4: d_req and i_req continuously alternating with x_req held -> x granted by the 5th contended cycle and x_ack follows. Non-guard build: x_ack never occurs in 50 cycles.
- Reset mid-flight: d read granted at N, reset=1 at N+1 -> no d_ack; at N+2 m_en=0 and d_rdata=0x0000.
- Throughput: i issues 8 consecutive reads of 0x00..0x07 alone -> one i_ack every 2 cycles with correct data. With d also issuing 8 reads, m_en is high every cycle.
